uart_rx_os: RTL



---
 rtl/uart_pkg.sv | 16 +
 rtl/sync2.sv | 25 ++
 rtl/uart_rx_os.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Frame state encoding and default frame geometry.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 4;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to 1 so an idle-high line never looks like a start bit.
module sync2 (
  input  logic clk,
  input  logic resetn,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver, LSB first.
// Advances only on tick; strobes self-clear on the next clk.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic w_rxs;

  sync2 u_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (rxd),
    .o_q    (w_rxs)
  );

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bit;
  logic [DATA_BITS-1:0]   r_sh;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_dv;
  logic                   r_fe;

  state_t                 w_state_nx;
  logic [CW-1:0]          w_cnt_nx;
  logic [BW-1:0]          w_bit_nx;
  logic [DATA_BITS-1:0]   w_sh_nx;
  logic [DATA_BITS-1:0]   w_data_nx;
  logic                   w_dv_nx;
  logic                   w_fe_nx;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_dv    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_sh    <= w_sh_nx;
      r_data  <= w_data_nx;
      r_dv    <= w_dv_nx;
      r_fe    <= w_fe_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_sh_nx    = r_sh;
    w_data_nx  = r_data;
    w_dv_nx    = 1'b0;
    w_fe_nx    = 1'b0;
    if (tick) begin
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            w_state_nx = START;
            w_cnt_nx   = '0;
          end
        end
        START: begin
          if (r_cnt == C_HALF) begin
            if (w_rxs) begin
              w_state_nx = IDLE;
            end else begin
              w_state_nx = DATA;
              w_cnt_nx   = '0;
              w_bit_nx   = '0;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == C_LAST) begin
            // right shift: first (LSB) bit ends up in bit 0
            w_sh_nx  = {w_rxs, r_sh[DATA_BITS-1:1]};
            w_cnt_nx = '0;
            w_bit_nx = r_bit + 1'b1;
            if (r_bit == B_LAST) begin
              w_state_nx = STOP;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == C_LAST) begin
            w_cnt_nx = '0;
            if (w_rxs) begin
              w_data_nx  = r_sh;
              w_dv_nx    = 1'b1;
              w_state_nx = IDLE;
            end else begin
              w_fe_nx    = 1'b1;
              w_state_nx = BREAK;
            end
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (w_rxs) begin
            w_state_nx = IDLE;
          end
        end
        default: begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
          w_bit_nx   = '0;
        end
      endcase
    end
  end

  assign data       = r_data;
  assign data_valid = r_dv;
  assign frame_err  = r_fe;
  assign busy       = (r_state != IDLE);

endmodule
